// File: rtl/snake_move_ctrl.sv
// Game control for the snake datapath: INIT/RUN/DEAD FSM, move-tick generation
// and direction capture with reverse-turn rejection.
module snake_move_ctrl #(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned CNT_W    = 25
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        BtnU,
  input  logic        BtnD,
  input  logic        BtnL,
  input  logic        BtnR,
  input  logic        Start,
  input  logic        Collision,
  output logic [1:0]  In_Dirn,
  output logic        SCEN,
  output logic        Q_Init,
  output logic        Q_Run,
  output logic        Q_Dead,
  output logic [15:0] Moves
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [15:0]      MOVES_MAX = 16'hFFFF;

  // One-hot encoding so the state register bits are the state outputs directly
  typedef enum logic [2:0] {
    INIT = 3'b001,
    RUN  = 3'b010,
    DEAD = 3'b100
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic [1:0]       pending;
  logic [1:0]       btn_code;
  logic [1:0]       ref_dirn;
  logic             btn_any;
  logic             btn_ok;
  logic             tick_edge;

  // Priority U > D > L > R; only one candidate per cycle
  always_comb begin
    btn_code = 2'b00;
    btn_any  = BtnU | BtnD | BtnL | BtnR;
    if (BtnU)      btn_code = 2'b00;
    else if (BtnD) btn_code = 2'b01;
    else if (BtnL) btn_code = 2'b10;
    else if (BtnR) btn_code = 2'b11;
  end

  assign tick_edge = (state == RUN) && (tick_cnt == TICK_LAST);

  // At the tick edge the value being committed is the reference, so two presses
  // in one period can never chain into a 180-degree turn
  assign ref_dirn = tick_edge ? pending : In_Dirn;
  assign btn_ok   = btn_any &&
                    !((btn_code[1] == ref_dirn[1]) && (btn_code[0] != ref_dirn[0]));

  assign Q_Init = state[0];
  assign Q_Run  = state[1];
  assign Q_Dead = state[2];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= INIT;
      tick_cnt <= '0;
      pending  <= 2'b00;
      In_Dirn  <= 2'b00;
      SCEN     <= 1'b0;
      Moves    <= 16'd0;
    end else begin
      SCEN <= 1'b0;
      case (state)
        INIT: begin
          if (Start) state <= RUN;
        end
        RUN: begin
          if (tick_edge) begin
            tick_cnt <= '0;
            SCEN     <= 1'b1;
            In_Dirn  <= pending;
            if (Moves != MOVES_MAX) Moves <= Moves + 16'd1;
          end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
          end
          if (btn_ok) pending <= btn_code;
          if (Collision) begin
            state    <= DEAD;
            tick_cnt <= '0;
          end
        end
        DEAD: begin
          // Final direction and score stay visible until the player restarts
          if (Start) begin
            state   <= INIT;
            Moves   <= 16'd0;
            In_Dirn <= 2'b00;
            pending <= 2'b00;
          end
        end
        default: begin
          state    <= INIT;
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl at TICK_DIV=4, plus a TICK_DIV=2 copy for
// the Moves saturation run.
module tb_snake_move_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0;
  logic        Start = 1'b0, Collision = 1'b0;
  logic [1:0]  In_Dirn;
  logic        SCEN, Q_Init, Q_Run, Q_Dead;
  logic [15:0] Moves;

  logic        Start2 = 1'b0;
  logic [1:0]  In_Dirn2;
  logic        SCEN2, Q_Init2, Q_Run2, Q_Dead2;
  logic [15:0] Moves2;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_moves = 0;

  always #5 Clk = ~Clk;

  snake_move_ctrl #(.TICK_DIV(4), .CNT_W(3)) dut (
    .Clk(Clk), .Reset(Reset),
    .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
    .Start(Start), .Collision(Collision),
    .In_Dirn(In_Dirn), .SCEN(SCEN),
    .Q_Init(Q_Init), .Q_Run(Q_Run), .Q_Dead(Q_Dead),
    .Moves(Moves)
  );

  snake_move_ctrl #(.TICK_DIV(2), .CNT_W(1)) dut_sat (
    .Clk(Clk), .Reset(Reset),
    .BtnU(1'b0), .BtnD(1'b0), .BtnL(1'b0), .BtnR(1'b0),
    .Start(Start2), .Collision(1'b0),
    .In_Dirn(In_Dirn2), .SCEN(SCEN2),
    .Q_Init(Q_Init2), .Q_Run(Q_Run2), .Q_Dead(Q_Dead2),
    .Moves(Moves2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  // Steps to the next SCEN-high cycle; checks the distance and the move count
  task automatic wait_scen(input string tag, input int exp_n);
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!SCEN && n < 64);
    check({tag, "_dist"}, 32'(n), 32'(exp_n));
    exp_moves++;
    check({tag, "_moves"}, 32'(Moves), 32'(exp_moves));
  endtask

  initial begin
    // Reset values
    #1 Reset = 1'b1;
    step();
    check("rst_init", 32'(Q_Init), 32'd1);
    check("rst_run",  32'(Q_Run),  32'd0);
    check("rst_dead", 32'(Q_Dead), 32'd0);
    check("rst_dirn", 32'(In_Dirn), 32'd0);
    check("rst_scen", 32'(SCEN), 32'd0);
    check("rst_moves", 32'(Moves), 32'd0);
    Reset = 1'b0;
    step();

    // 1: start, strobe cadence, move count
    Start = 1'b1; step(); Start = 1'b0;
    check("t1_run", 32'(Q_Run), 32'd1);
    check("t1_init", 32'(Q_Init), 32'd0);
    wait_scen("t1_first", 4);
    check("t1_dirn", 32'(In_Dirn), 32'd0);
    step();
    check("t1_scen_low", 32'(SCEN), 32'd0);
    wait_scen("t1_second", 3);
    wait_scen("t1_third", 4);
    check("t1_moves3", 32'(Moves), 32'd3);

    // 2: Left accepted, then Right rejected as reverse
    step();
    BtnL = 1'b1; step(); BtnL = 1'b0;
    wait_scen("t2_left", 2);
    check("t2_dirn_l", 32'(In_Dirn), 32'b10);
    BtnR = 1'b1; step(); BtnR = 1'b0;
    wait_scen("t2_r1", 3);
    check("t2_dirn_r1", 32'(In_Dirn), 32'b10);
    wait_scen("t2_r2", 4);
    check("t2_dirn_r2", 32'(In_Dirn), 32'b10);

    // 3: back to Up; L then D within one period; U+R together
    BtnU = 1'b1; step(); BtnU = 1'b0;
    wait_scen("t3_up", 3);
    check("t3_dirn_u", 32'(In_Dirn), 32'b00);
    BtnL = 1'b1; step(); BtnL = 1'b0;
    BtnD = 1'b1; step(); BtnD = 1'b0;
    wait_scen("t3_ld", 2);
    check("t3_dirn_ld", 32'(In_Dirn), 32'b10);
    BtnU = 1'b1; BtnR = 1'b1; step(); BtnU = 1'b0; BtnR = 1'b0;
    wait_scen("t3_ur", 3);
    check("t3_dirn_ur", 32'(In_Dirn), 32'b00);

    // 4: Right pressed in the tick-edge cycle lands one tick later
    step(); step(); step();
    BtnR = 1'b1; step(); BtnR = 1'b0;
    exp_moves++;
    check("t4_scen", 32'(SCEN), 32'd1);
    check("t4_dirn_now", 32'(In_Dirn), 32'b00);
    check("t4_moves", 32'(Moves), 32'(exp_moves));
    wait_scen("t4_next", 4);
    check("t4_dirn_next", 32'(In_Dirn), 32'b11);

    // Reference at the tick edge is Pending: Down rejected against pending Up
    BtnU = 1'b1; step(); BtnU = 1'b0;
    step(); step();
    BtnD = 1'b1; step(); BtnD = 1'b0;
    exp_moves++;
    check("t4b_scen", 32'(SCEN), 32'd1);
    check("t4b_dirn_u", 32'(In_Dirn), 32'b00);
    wait_scen("t4b_next", 4);
    check("t4b_dirn_keep", 32'(In_Dirn), 32'b00);

    // 5: collision on a tick edge
    step(); step(); step();
    Collision = 1'b1; step(); Collision = 1'b0;
    exp_moves++;
    check("t5_scen", 32'(SCEN), 32'd1);
    check("t5_dead", 32'(Q_Dead), 32'd1);
    check("t5_moves", 32'(Moves), 32'(exp_moves));
    step();
    check("t5_scen_low", 32'(SCEN), 32'd0);
    BtnL = 1'b1; step(); BtnL = 1'b0;
    repeat (8) step();
    check("t5_scen_hold", 32'(SCEN), 32'd0);
    check("t5_moves_hold", 32'(Moves), 32'(exp_moves));
    check("t5_dirn_hold", 32'(In_Dirn), 32'b00);
    check("t5_still_dead", 32'(Q_Dead), 32'd1);
    Start = 1'b1; step(); Start = 1'b0;
    exp_moves = 0;
    check("t5_init", 32'(Q_Init), 32'd1);
    check("t5_init_moves", 32'(Moves), 32'd0);
    BtnL = 1'b1; step(); BtnL = 1'b0;
    check("t5_init_hold", 32'(Q_Init), 32'd1);
    Start = 1'b1; step(); Start = 1'b0;
    check("t5_rerun", 32'(Q_Run), 32'd1);
    Start = 1'b1; step(); Start = 1'b0;
    check("t5_start_ign", 32'(Q_Run), 32'd1);
    wait_scen("t5_first", 3);
    check("t5_dirn_clr", 32'(In_Dirn), 32'b00);

    // 6: asynchronous reset mid-period
    BtnL = 1'b1; step(); BtnL = 1'b0;
    wait_scen("t6_left", 3);
    check("t6_dirn_pre", 32'(In_Dirn), 32'b10);
    @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    check("t6_init", 32'(Q_Init), 32'd1);
    check("t6_run", 32'(Q_Run), 32'd0);
    check("t6_dirn", 32'(In_Dirn), 32'd0);
    check("t6_moves", 32'(Moves), 32'd0);
    check("t6_scen", 32'(SCEN), 32'd0);
    step();
    Reset = 1'b0;
    step();

    // Saturation on the fast instance: one SCEN every two RUN edges
    Start2 = 1'b1; step(); Start2 = 1'b0;
    check("sat_run", 32'(Q_Run2), 32'd1);
    repeat (2000) step();
    check("sat_1000", 32'(Moves2), 32'd1000);
    repeat (2 * 64535) step();
    check("sat_65535", 32'(Moves2), 32'd65535);
    repeat (2 * 5000) step();
    check("sat_hold", 32'(Moves2), 32'd65535);
    check("sat_still_run", 32'(Q_Run2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
